// File: rtl/matrix_mult_host_pkg.sv
// Shared definitions for the matrix multiplier host: element width,
// controller state encoding and the packed-bus width helper.
package matrix_mult_host_pkg;

  localparam int ELEMENT_LENGTH = 32;

  typedef enum logic [2:0] {
    FILL  = 3'd0,
    LOAD  = 3'd1,
    WAIT  = 3'd2,
    ACK   = 3'd3,
    DRAIN = 3'd4
  } state_t;

  // Width of a flat bus carrying n elements, element 0 in the MSBs.
  function automatic int bus_width(input int n);
    return ELEMENT_LENGTH * n;
  endfunction

endpackage

// File: rtl/matrix_mult_host_serializer.sv
// Streams the elements of a flat bus out one at a time, element 0 first.
// Handshake: a beat transfers on a rising edge where m_valid && m_ready;
// m_data/m_last stay stable while m_valid is high and m_ready is low.
module mat_serializer
  import matrix_mult_host_pkg::*;
#(
  parameter int N  = 4,
  parameter int CW = $clog2(N + 1)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      en,
  input  logic [bus_width(N)-1:0]   data,
  input  logic                      m_ready,
  output logic [ELEMENT_LENGTH-1:0] m_data,
  output logic                      m_valid,
  output logic                      m_last,
  output logic                      done
);

  localparam int BW = bus_width(N);

  logic [CW-1:0]             ocnt;
  logic [ELEMENT_LENGTH-1:0] elem;

  // Element index: advances per accepted beat, parks at zero when idle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ocnt <= '0;
    end else if (!en) begin
      ocnt <= '0;
    end else if (m_ready) begin
      ocnt <= (ocnt == CW'(N - 1)) ? '0 : ocnt + CW'(1);
    end
  end

  // Select the current element and form the stream outputs.
  always_comb begin
    elem = '0;
    for (int e = 0; e < N; e++) begin
      if (ocnt == CW'(e)) elem = data[BW-1-ELEMENT_LENGTH*e -: ELEMENT_LENGTH];
    end
    m_valid = en;
    m_data  = en ? elem : '0;
    m_last  = en && (ocnt == CW'(N - 1));
    done    = en && m_ready && (ocnt == CW'(N - 1));
  end

endmodule

// File: rtl/matrix_mult_host.sv
// Host-side driver for the matrix multiplier: collects A then B from a
// serial element stream, issues a one-cycle load, waits for the result
// (masking the first cycle after load), acknowledges it and streams the
// product out row-major.
// Input handshake: an element is taken on a rising edge where
// s_valid && s_ready; s_ready is high only while filling.
module matrix_mult_host
  import matrix_mult_host_pkg::*;
#(
  parameter int NUM_FIRST_ROW  = 2,
  parameter int NUM_FIRST_COL  = 2,
  parameter int NUM_SECOND_COL = 2
) (
  input  logic                                                  clk,
  input  logic                                                  rst,
  input  logic [ELEMENT_LENGTH-1:0]                             s_data,
  input  logic                                                  s_valid,
  output logic                                                  s_ready,
  output logic [bus_width(NUM_FIRST_ROW*NUM_FIRST_COL)-1:0]     mm_In1,
  output logic [bus_width(NUM_FIRST_COL*NUM_SECOND_COL)-1:0]    mm_In2,
  output logic                                                  mm_load,
  input  logic [bus_width(NUM_FIRST_ROW*NUM_SECOND_COL)-1:0]    mm_Out,
  input  logic                                                  mm_ready,
  output logic                                                  mm_ack,
  output logic [ELEMENT_LENGTH-1:0]                             m_data,
  output logic                                                  m_valid,
  input  logic                                                  m_ready,
  output logic                                                  m_last,
  output logic                                                  busy,
  output logic [2:0]                                            dbg_state
);

  localparam int NA  = NUM_FIRST_ROW * NUM_FIRST_COL;
  localparam int NB  = NUM_FIRST_COL * NUM_SECOND_COL;
  localparam int NO  = NUM_FIRST_ROW * NUM_SECOND_COL;
  localparam int NIN = NA + NB;
  localparam int CW  = $clog2(NIN + 1);
  localparam int AW  = bus_width(NA);
  localparam int BW  = bus_width(NB);
  localparam int OW  = bus_width(NO);

  state_t        state, next_state;
  logic [CW-1:0] cnt;
  logic          wait_mask;
  logic [OW-1:0] out_buf;
  logic          take;
  logic          capture;
  logic          drain_done;

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= FILL;
    else      state <= next_state;
  end

  // Next-state and control outputs decoded from the current state.
  always_comb begin
    next_state = state;
    s_ready    = 1'b0;
    mm_load    = 1'b0;
    mm_ack     = 1'b0;
    take       = 1'b0;
    capture    = 1'b0;
    busy       = 1'b1;
    case (state)
      FILL: begin
        s_ready = 1'b1;
        take    = s_valid;
        busy    = (cnt != '0);
        if (s_valid && cnt == CW'(NIN - 1)) next_state = LOAD;
      end
      LOAD: begin
        mm_load    = 1'b1;
        next_state = WAIT;
      end
      WAIT: begin
        capture = !wait_mask && mm_ready;
        if (capture) next_state = ACK;
      end
      ACK: begin
        mm_ack     = 1'b1;
        next_state = DRAIN;
      end
      DRAIN: begin
        if (drain_done) next_state = FILL;
      end
      default: next_state = FILL;
    endcase
  end

  // Operand packing, wait-cycle mask and result capture.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt       <= '0;
      wait_mask <= 1'b0;
      mm_In1    <= '0;
      mm_In2    <= '0;
      out_buf   <= '0;
    end else begin
      case (state)
        FILL: begin
          if (take) begin
            for (int e = 0; e < NA; e++) begin
              if (cnt == CW'(e)) mm_In1[AW-1-ELEMENT_LENGTH*e -: ELEMENT_LENGTH] <= s_data;
            end
            for (int e = 0; e < NB; e++) begin
              if (cnt == CW'(NA + e)) mm_In2[BW-1-ELEMENT_LENGTH*e -: ELEMENT_LENGTH] <= s_data;
            end
            cnt <= (cnt == CW'(NIN - 1)) ? '0 : cnt + CW'(1);
          end
        end
        LOAD: wait_mask <= 1'b1;
        WAIT: begin
          wait_mask <= 1'b0;
          if (capture) out_buf <= mm_Out;
        end
        ACK, DRAIN: ;
        default: begin
          cnt       <= '0;
          wait_mask <= 1'b0;
        end
      endcase
    end
  end

  mat_serializer #(.N(NO)) u_serializer (
    .clk     (clk),
    .rst     (rst),
    .en      (state == DRAIN),
    .data    (out_buf),
    .m_ready (m_ready),
    .m_data  (m_data),
    .m_valid (m_valid),
    .m_last  (m_last),
    .done    (drain_done)
  );

  assign dbg_state = state;

endmodule

// File: tb/tb_matrix_mult_host.sv
// Bench for matrix_mult_host: random and directed jobs, a behavioural
// multiplier peer, and a scoreboard of expected operand buses and
// expected output beats.
module tb_matrix_mult_host;
  import matrix_mult_host_pkg::*;

  localparam int NA = 4, NB = 4, NO = 4;

  logic           clk, rst;
  logic [31:0]    s_data;
  logic           s_valid, s_ready;
  logic [127:0]   mm_In1, mm_In2, mm_Out;
  logic           mm_load, mm_ready, mm_ack;
  logic [31:0]    m_data;
  logic           m_valid, m_ready, m_last, busy;
  logic [2:0]     dbg_state;

  int checks = 0, errors = 0;
  logic [32:0]  exp_q[$];
  logic [127:0] exp_in1_q[$];
  logic [127:0] exp_in2_q[$];
  logic [127:0] cur_in1, cur_in2;
  int jobs_issued = 0, loads_seen = 0, acks_seen = 0, beats_seen = 0;
  int mm_mode = 0;       // 0 random delay, 1 fixed 10-cycle result, 2 stale ready
  int m_ready_mode = 0;  // 0 always, 1 random, 2 pattern 1,0,0,1
  int pi = 0;
  logic [3:0] pat = 4'b1001;
  logic prev_load = 0, prev_ack = 0, after_last = 0, hold_pending = 0;
  logic [32:0] hold_val;

  matrix_mult_host dut (
    .clk(clk), .rst(rst), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .mm_In1(mm_In1), .mm_In2(mm_In2), .mm_load(mm_load), .mm_Out(mm_Out),
    .mm_ready(mm_ready), .mm_ack(mm_ack), .m_data(m_data), .m_valid(m_valid),
    .m_ready(m_ready), .m_last(m_last), .busy(busy), .dbg_state(dbg_state)
  );

  // Clock
  initial clk = 0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not complete, got timeout required completion");
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic timeout_fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s: got no response expected handshake within budget", name);
  endtask

  function automatic logic [127:0] pack4(input logic [31:0] w[4]);
    logic [127:0] p = '0;
    for (int e = 0; e < 4; e++) p = (p << 32) | {96'b0, w[e]};
    return p;
  endfunction

  // Driver: present one element (entered and left at a falling edge).
  task automatic send_elem(input logic [31:0] d, input int gap);
    int t = 0;
    for (int g = 0; g < gap; g++) begin
      s_valid = 0;
      @(negedge clk);
    end
    s_valid = 1;
    s_data  = d;
    while (!s_ready && t < 4000) begin
      @(negedge clk);
      t++;
    end
    if (!s_ready) timeout_fail("s_ready_wait");
    @(negedge clk);
  endtask

  task automatic send_job(input logic [31:0] a[4], input logic [31:0] b[4],
                          input int max_gap, input bit drop_after);
    exp_in1_q.push_back(pack4(a));
    exp_in2_q.push_back(pack4(b));
    jobs_issued++;
    for (int e = 0; e < NA; e++) send_elem(a[e], $urandom_range(0, max_gap));
    for (int e = 0; e < NB; e++) send_elem(b[e], $urandom_range(0, max_gap));
    if (drop_after) s_valid = 0;
  endtask

  task automatic rand_mats(output logic [31:0] a[4], output logic [31:0] b[4]);
    for (int e = 0; e < 4; e++) begin
      a[e] = $urandom();
      b[e] = $urandom();
    end
  endtask

  task automatic wait_done();
    int t = 0;
    while (beats_seen < jobs_issued * NO && t < 3000) begin
      @(negedge clk);
      t++;
    end
    if (beats_seen < jobs_issued * NO) timeout_fail("drain_wait");
  endtask

  // Behavioural multiplier peer: answers each load with a result word set.
  initial begin : mult_model
    int mode, delay, t;
    logic [31:0] res[4];
    logic [31:0] junk[4];
    logic [31:0] fixed[4];
    fixed[0] = 32'h3F800000; fixed[1] = 32'h40000000;
    fixed[2] = 32'h40400000; fixed[3] = 32'h40800000;
    mm_ready = 0;
    mm_Out   = '0;
    forever begin
      @(negedge clk);
      if (rst && mm_load) begin
        mode = mm_mode;
        for (int e = 0; e < 4; e++) begin
          res[e]  = (mode == 1) ? fixed[e] : $urandom();
          junk[e] = ~res[e];
        end
        if (mode == 2) begin
          // Stale result visible through LOAD and the masked cycle.
          mm_Out   = pack4(junk);
          mm_ready = 1;
          @(negedge clk);
          @(negedge clk);
        end else begin
          delay = (mode == 1) ? 10 : $urandom_range(1, 12);
          repeat (delay) @(negedge clk);
        end
        mm_Out   = pack4(res);
        mm_ready = 1;
        for (int e = 0; e < NO; e++) exp_q.push_back({(e == NO - 1), res[e]});
        t = 0;
        do begin
          @(negedge clk);
          t++;
        end while (!mm_ack && t < 500);
        if (!mm_ack) timeout_fail("mm_ack_wait");
        if (mode != 2) mm_ready = 0;
      end else begin
        mm_ready = (mm_mode == 2);
      end
    end
  end

  // Downstream ready driver, changed just after the rising edge.
  always @(posedge clk) begin
    #1;
    case (m_ready_mode)
      0: m_ready = 1;
      1: m_ready = 1'($urandom_range(0, 1));
      default: begin
        if (m_valid) begin
          m_ready = pat[3 - (pi % 4)];
          pi++;
        end else begin
          m_ready = 1;
          pi = 0;
        end
      end
    endcase
  end

  // Load/ack monitor: operand buses against the scoreboard, pulse widths.
  always @(negedge clk) begin
    if (rst) begin
      if (mm_load) begin
        loads_seen++;
        check("mm_load_single_cycle", {127'b0, prev_load}, 128'd0);
        if (exp_in1_q.size() == 0) timeout_fail("unexpected_load");
        else begin
          cur_in1 = exp_in1_q.pop_front();
          cur_in2 = exp_in2_q.pop_front();
          check("mm_In1", mm_In1, cur_in1);
          check("mm_In2", mm_In2, cur_in2);
        end
      end
      if (mm_ack) begin
        acks_seen++;
        check("mm_ack_single_cycle", {127'b0, prev_ack}, 128'd0);
        check("mm_In1_held", mm_In1, cur_in1);
        check("mm_In2_held", mm_In2, cur_in2);
      end
    end
    prev_load = mm_load;
    prev_ack  = mm_ack;
  end

  // Output monitor: pops the expected beat for every accepted output.
  always @(negedge clk) begin
    if (rst) begin
      if (after_last) begin
        check("refill_after_last", {125'b0, s_ready, busy, m_valid}, 128'b100);
        after_last = 0;
      end
      if (m_valid) begin
        check("s_ready_low_in_drain", {127'b0, s_ready}, 128'd0);
        check("busy_in_drain", {127'b0, busy}, 128'd1);
        if (hold_pending) begin
          check("m_stream_held", {95'b0, m_last, m_data}, {95'b0, hold_val});
          hold_pending = 0;
        end
        if (m_ready) begin
          beats_seen++;
          if (exp_q.size() == 0) timeout_fail("unexpected_beat");
          else begin
            logic [32:0] ev;
            ev = exp_q.pop_front();
            check("m_data", {96'b0, m_data}, {96'b0, ev[31:0]});
            check("m_last", {127'b0, m_last}, {127'b0, ev[32]});
          end
          after_last = m_last;
        end else begin
          hold_pending = 1;
          hold_val = {m_last, m_data};
        end
      end
    end else begin
      after_last   = 0;
      hold_pending = 0;
    end
  end

  // Main sequence
  initial begin : main_seq
    logic [31:0] a[4];
    logic [31:0] b[4];
    rst = 0;
    s_valid = 0;
    s_data = '0;
    repeat (3) @(negedge clk);
    check("rst_s_ready", {127'b0, s_ready}, 128'd1);
    check("rst_busy", {127'b0, busy}, 128'd0);
    check("rst_pulses", {126'b0, mm_load, mm_ack}, 128'd0);
    check("rst_stream", {95'b0, m_valid, m_last, m_data}, 128'd0);
    check("rst_In1", mm_In1, 128'd0);
    check("rst_In2", mm_In2, 128'd0);
    check("rst_state", {125'b0, dbg_state}, 128'd0);
    rst = 1;
    @(negedge clk);

    // Identity times [1,2;3,4], peer answers after 10 cycles.
    mm_mode = 1;
    m_ready_mode = 0;
    a[0] = 32'h3F800000; a[1] = 32'h0; a[2] = 32'h0; a[3] = 32'h3F800000;
    b[0] = 32'h3F800000; b[1] = 32'h40000000; b[2] = 32'h40400000; b[3] = 32'h40800000;
    send_job(a, b, 0, 1);
    @(negedge clk);
    check("busy_after_fill", {127'b0, busy}, 128'd1);
    wait_done();

    // Stalling downstream with the 1,0,0,1 ready pattern.
    m_ready_mode = 2;
    rand_mats(a, b);
    send_job(a, b, 0, 1);
    wait_done();

    // Reset after 3 of 8 elements discards the partial fill.
    mm_mode = 0;
    m_ready_mode = 1;
    for (int e = 0; e < 3; e++) send_elem($urandom(), 0);
    s_valid = 0;
    check("busy_mid_fill", {127'b0, busy}, 128'd1);
    rst = 0;
    #1;
    check("midrst_s_ready", {127'b0, s_ready}, 128'd1);
    check("midrst_busy", {127'b0, busy}, 128'd0);
    check("midrst_In1", mm_In1, 128'd0);
    @(negedge clk);
    rst = 1;
    @(negedge clk);
    rand_mats(a, b);
    send_job(a, b, 2, 1);
    wait_done();

    // Stale mm_ready held high across two jobs.
    mm_mode = 2;
    m_ready_mode = 0;
    repeat (2) @(negedge clk);
    for (int j = 0; j < 2; j++) begin
      rand_mats(a, b);
      send_job(a, b, 1, 1);
      wait_done();
    end
    mm_mode = 0;
    repeat (2) @(negedge clk);

    // Back-to-back jobs with s_valid held high between them.
    rand_mats(a, b);
    send_job(a, b, 0, 0);
    rand_mats(a, b);
    send_job(a, b, 0, 1);
    wait_done();

    // Random jobs, random gaps and downstream stalls.
    m_ready_mode = 1;
    for (int j = 0; j < 4; j++) begin
      rand_mats(a, b);
      send_job(a, b, 3, 1);
    end
    wait_done();
    repeat (5) @(negedge clk);

    check("load_count", 128'(loads_seen), 128'(jobs_issued));
    check("ack_count", 128'(acks_seen), 128'(jobs_issued));
    check("beats_count", 128'(beats_seen), 128'(jobs_issued * NO));
    check("exp_q_empty", 128'(exp_q.size()), 128'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
